rob_multiport: RTL

- Parametrised reorder buffer. Successor to the single-entry-type ROB definitions.
- Circular buffer of DEPTH entries with N-wide in-order allocate, M writeback ports and N-wide in-order commit.
- Sits between rename/dispatch (allocate), the execute units (writeback) and architectural-state retire (commit).
- Payload (pc, next_pc, uop, physical regs) is opaque, PAYLOAD_W bits wide. The ROB tracks only status and ordering.

---
 rtl/rob_multiport.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rob_multiport.sv
// Multi-port reorder buffer: N-wide in-order allocate, M writeback ports, N-wide in-order commit.
// Optional macro ROB_WB_BYPASS_EN forwards same-cycle writebacks into commit evaluation.
module rob_multiport #(
    parameter int DEPTH          = 128,
    parameter int DISPATCH_WIDTH = 2,
    parameter int COMMIT_WIDTH   = 2,
    parameter int WB_PORTS       = 2,
    parameter int PAYLOAD_W      = 128,
    localparam int PTR_W         = $clog2(DEPTH)
) (
    input  logic                                clk_in,
    input  logic                                rst_N_in,
    input  logic [DISPATCH_WIDTH-1:0]           alloc_valid_in,
    input  logic [DISPATCH_WIDTH*PAYLOAD_W-1:0] alloc_payload_in,
    output logic                                alloc_ready_out,
    output logic [DISPATCH_WIDTH*PTR_W-1:0]     alloc_ptr_out,
    input  logic [WB_PORTS-1:0]                 wb_valid_in,
    input  logic [WB_PORTS*PTR_W-1:0]           wb_ptr_in,
    input  logic [WB_PORTS-1:0]                 wb_exc_in,
    output logic [COMMIT_WIDTH-1:0]             commit_valid_out,
    output logic [COMMIT_WIDTH*PAYLOAD_W-1:0]   commit_payload_out,
    output logic                                commit_exc_out,
    input  logic                                commit_ready_in,
    input  logic                                flush_in,
    output logic [PTR_W:0]                      count_out,
    output logic                                empty_out
);
    typedef enum logic [1:0] {ST_FREE, ST_ISSUED, ST_DONE, ST_EXC} status_e;

    status_e              r_status  [DEPTH];
    logic [PAYLOAD_W-1:0] r_payload [DEPTH];
    logic [PTR_W:0]       r_head;
    logic [PTR_W:0]       r_tail;

    logic [PTR_W:0]            w_count;
    logic [DISPATCH_WIDTH-1:0] w_alloc_en;
    logic [PTR_W:0]            w_alloc_k;
    logic [PTR_W:0]            w_commit_k;
    logic                      w_flush;
    status_e                   w_cstat [COMMIT_WIDTH];

    // Pointers carry a wrap bit, so the difference is the occupancy and full differs from empty.
    assign w_count         = r_tail - r_head;
    assign count_out       = w_count;
    assign empty_out       = (w_count == '0);
    assign alloc_ready_out = ({1'b0, w_count} + (PTR_W+2)'(DISPATCH_WIDTH)) <= (PTR_W+2)'(DEPTH);
    assign w_flush         = flush_in || (commit_ready_in && commit_exc_out);

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        logic run;
        run           = 1'b1;
        w_alloc_en    = '0;
        w_alloc_k     = '0;
        alloc_ptr_out = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            run           = run & alloc_valid_in[i];
            w_alloc_en[i] = run;
            if (run) w_alloc_k = w_alloc_k + (PTR_W+1)'(1);
            alloc_ptr_out[i*PTR_W +: PTR_W] = r_tail[PTR_W-1:0] + PTR_W'(i);
        end
    end

    // Status as seen by commit; with the bypass, writebacks to the commit window land this cycle.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx                = '0;
        commit_payload_out = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            idx        = r_head[PTR_W-1:0] + PTR_W'(i);
            w_cstat[i] = r_status[idx];
`ifdef ROB_WB_BYPASS_EN
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid_in[p] && (wb_ptr_in[p*PTR_W +: PTR_W] == idx) && (r_status[idx] == ST_ISSUED))
                    w_cstat[i] = wb_exc_in[p] ? ST_EXC : ST_DONE;
            end
`endif
            commit_payload_out[i*PAYLOAD_W +: PAYLOAD_W] = r_payload[idx];
        end
    end

    always_comb begin
        logic run;
        run              = 1'b1;
        commit_valid_out = '0;
        commit_exc_out   = 1'b0;
        w_commit_k       = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (run && ((PTR_W+1)'(i) < w_count) && (w_cstat[i] == ST_DONE)) begin
                commit_valid_out[i] = 1'b1;
                w_commit_k          = w_commit_k + (PTR_W+1)'(1);
            end else begin
                // An excepting entry retires alone, and only from the head.
                if (i == 0 && w_count != '0 && w_cstat[0] == ST_EXC) begin
                    commit_valid_out[0] = 1'b1;
                    commit_exc_out      = 1'b1;
                    w_commit_k          = (PTR_W+1)'(1);
                end
                run = 1'b0;
            end
        end
    end

    // NOTE: non-blocking assignments; when several target one entry the last in program order wins,
    // which gives the higher writeback port priority and lets commit-free override a bypassed writeback.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            r_head <= '0;
            r_tail <= '0;
            for (int i = 0; i < DEPTH; i++) r_status[i] <= ST_FREE;
        end else if (w_flush) begin
            r_tail <= r_head;
            for (int i = 0; i < DEPTH; i++) r_status[i] <= ST_FREE;
        end else begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid_in[p] && (r_status[wb_ptr_in[p*PTR_W +: PTR_W]] == ST_ISSUED))
                    r_status[wb_ptr_in[p*PTR_W +: PTR_W]] <= wb_exc_in[p] ? ST_EXC : ST_DONE;
            end
            if (commit_ready_in) begin
                for (int i = 0; i < COMMIT_WIDTH; i++) begin
                    if (commit_valid_out[i]) r_status[r_head[PTR_W-1:0] + PTR_W'(i)] <= ST_FREE;
                end
                r_head <= r_head + w_commit_k;
            end
            if (alloc_ready_out) begin
                for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                    if (w_alloc_en[i]) r_status[r_tail[PTR_W-1:0] + PTR_W'(i)] <= ST_ISSUED;
                end
                r_tail <= r_tail + w_alloc_k;
            end
        end
    end

    // NOTE: the payload RAM is deliberately not reset; status alone decides whether an entry is live.
    always_ff @(posedge clk_in) begin
        if (alloc_ready_out && !w_flush) begin
            for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                if (w_alloc_en[i])
                    r_payload[r_tail[PTR_W-1:0] + PTR_W'(i)] <= alloc_payload_in[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

`ifndef SYNTHESIS
    a_alloc_held: assert property (@(posedge clk_in) disable iff (!rst_N_in)
        (!alloc_ready_out && !w_flush) |=> (r_tail == $past(r_tail)));
    a_alloc_packed: assert property (@(posedge clk_in) disable iff (!rst_N_in)
        ((alloc_valid_in & (alloc_valid_in + DISPATCH_WIDTH'(1))) == '0));
`endif
endmodule
